// File: rtl/tx_lane_scheduler.sv
// Round-robin scheduler sharing one byte-wide transmitter between NUM_CH FIFO channels.
// Optional macro TX_SCHED_PRIO_EN gives channel 0 strict priority over the round-robin group.
module tx_lane_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int BUSY_WAIT = 3
) (
    input  logic                  clk100_i,
    input  logic                  rstn_i,
    input  logic [NUM_CH-1:0]     ch_enable_i,
    input  logic [NUM_CH-1:0]     fifo_empty_i,
    input  logic [8*NUM_CH-1:0]   fifo_data_i,
    output logic [NUM_CH-1:0]     fifo_re_o,
    input  logic                  tx_busy_i,
    output logic                  tx_start_o,
    output logic [7:0]            tx_data_o,
    output logic [CH_W-1:0]       tx_ch_o,
    output logic                  sched_busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    localparam int CNT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    // wait_cnt counts WAIT_HI cycles from 0; the BUSY_WAIT-th one without busy ends the wait
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BUSY_WAIT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   rr;
    logic [CNT_W-1:0]  wait_cnt;
    logic [NUM_CH-1:0] elig;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;

    // Returns {found, index} of the first requester strictly after 'last', wrapping.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   last);
        logic            found;
        logic [CH_W-1:0] idx;
        int              c;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (int'(last) + k) % NUM_CH;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = CH_W'(c);
            end
        end
        return {found, idx};
    endfunction

    assign elig = ch_enable_i & ~fifo_empty_i;

`ifdef TX_SCHED_PRIO_EN
    localparam logic [NUM_CH-1:0] RR_MASK = {{(NUM_CH-1){1'b1}}, 1'b0};

    always_comb begin
        {grant_vld, grant_ch} = rr_pick(elig & RR_MASK, rr);
        if (elig[0]) begin
            grant_vld = 1'b1;
            grant_ch  = '0;
        end
    end
`else
    assign {grant_vld, grant_ch} = rr_pick(elig, rr);
`endif

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= S_IDLE;
            rr        <= CH_W'(NUM_CH - 1);
            tx_ch_o   <= '0;
            tx_data_o <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (!tx_busy_i && grant_vld)
                        tx_ch_o <= grant_ch;
                end
                S_LATCH: tx_data_o <= fifo_data_i[8*tx_ch_o +: 8];
                S_START: begin
                    wait_cnt <= '0;
`ifdef TX_SCHED_PRIO_EN
                    // channel-0 grants leave the round-robin position untouched
                    if (tx_ch_o != '0)
                        rr <= tx_ch_o;
`else
                    rr <= tx_ch_o;
`endif
                end
                S_WAIT_HI: begin
                    if (!tx_busy_i && wait_cnt != WAIT_LAST)
                        wait_cnt <= wait_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        fifo_re_o  = '0;
        tx_start_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (!tx_busy_i && grant_vld)
                    state_nxt = S_POP;
            end
            S_POP: begin
                fifo_re_o[tx_ch_o] = 1'b1;
                state_nxt          = S_LATCH;
            end
            S_LATCH: state_nxt = S_START;
            S_START: begin
                tx_start_o = 1'b1;
                state_nxt  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy_i)
                    state_nxt = S_WAIT_LO;
                else if (wait_cnt == WAIT_LAST)
                    state_nxt = S_IDLE;
            end
            S_WAIT_LO: begin
                if (!tx_busy_i)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sched_busy_o = (state != S_IDLE);

endmodule
